// File: rtl/router_wrap_input_credit_fifo.sv
// Input-port flit buffer with credit return toward the upstream link.
// Each dequeue pulses iack_d so the sender regains one credit per flit.
module router_wrap_input_credit_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  iack_d,
   output logic [PTR_WIDTH:0]    occupancy,
   output logic                  overflow
);

   localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic                  ovf_q, ovf_d;

   logic full;
   logic deq;
   logic enq;
   logic drop;

   // Handshake inputs are ignored while reset is asserted.
   always_comb begin
      full = (count_q == CNT_FULL);
      out_valid = (count_q != '0);
      deq  = out_valid & out_ready & ~reset;
      enq  = in_valid & ~reset & (~full | deq);
      drop = in_valid & ~reset & full & ~deq;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | drop;
      if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({enq, deq})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; out_data is only meaningful with out_valid.
   always_ff @(posedge clk) begin
      if (enq) mem_q[wr_ptr_q] <= in_data;
   end

   assign out_data  = mem_q[rd_ptr_q];
   assign iack_d    = deq;
   assign occupancy = count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_router_wrap_input_credit_fifo.sv
// Bench for the input credit FIFO: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_router_wrap_input_credit_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int PW    = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          iack_d;
   logic [PW:0]   occupancy;
   logic          overflow;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mq[$];
   bit            m_ovf = 1'b0;
   bit            known = 1'b0;
   logic [DW-1:0] dlog[$];
   int            iack_cnt = 0;

   always #5 clk = ~clk;

   router_wrap_input_credit_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .iack_d(iack_d),
      .occupancy(occupancy),
      .overflow(overflow)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check before the posedge, then
   // advance the model with the rules a FIFO with credits obeys.
   task automatic step(input bit r, input bit iv,
                       input logic [DW-1:0] d, input bit rdy);
      bit full;
      bit deq;
      @(negedge clk);
      reset = r;
      in_valid = iv;
      in_data = d;
      out_ready = rdy;
      #1;
      deq = !r && mq.size() != 0 && rdy;
      if (known) begin
         chk("occupancy", 64'(occupancy), 64'(mq.size()));
         chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (mq.size() != 0) chk("out_data", 64'(out_data), 64'(mq[0]));
      end
      chk("iack_d", 64'(iack_d), 64'(deq));
      if (iack_d === 1'b1) begin
         dlog.push_back(out_data);
         iack_cnt++;
      end
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         known = 1'b1;
      end else begin
         full = (mq.size() == DEPTH);
         if (deq) void'(mq.pop_front());
         if (iv) begin
            if (!full || deq) mq.push_back(d);
            else m_ovf = 1'b1;
         end
      end
   endtask

   initial begin
      int sent;
      int budget;
      bit hit;

      step(1, 0, '0, 0);
      step(1, 0, '0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, '0, 1);

      // Fill then drain
      for (int i = 0; i < 4; i++) begin
         step(0, 1, DW'(32'hA0 + i), 0);
         #1 chk("fill_occ", 64'(occupancy), 64'(i + 1));
      end
      dlog.delete();
      iack_cnt = 0;
      for (int i = 0; i < 5; i++) step(0, 0, '0, 1);
      chk("drain_cnt", 64'(iack_cnt), 64'd4);
      for (int i = 0; i < 4 && i < dlog.size(); i++)
         chk("drain_data", 64'(dlog[i]), 64'(32'hA0 + i));
      #1 chk("drain_occ", 64'(occupancy), 64'd0);

      // Full with simultaneous enqueue and dequeue
      for (int i = 0; i < 4; i++) step(0, 1, DW'(32'hA0 + i), 0);
      dlog.delete();
      step(0, 1, DW'(32'hB0), 1);
      #1 chk("fs_occ", 64'(occupancy), 64'd4);
      chk("fs_ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
      chk("fs_len", 64'(dlog.size()), 64'd5);
      if (dlog.size() == 5) chk("fs_b0_4th", 64'(dlog[4]), 64'hB0);

      // Overflow drop is sticky
      for (int i = 0; i < 4; i++) step(0, 1, DW'(32'hC0 + i), 0);
      step(0, 1, DW'(32'hCC), 0);
      #1 chk("ov_flag", 64'(overflow), 64'd1);
      chk("ov_occ", 64'(occupancy), 64'd4);
      dlog.delete();
      for (int i = 0; i < 5; i++) step(0, 0, '0, 1);
      hit = 1'b0;
      foreach (dlog[i]) if (dlog[i] == 32'hCC) hit = 1'b1;
      chk("ov_no_cc", 64'(hit), 64'd0);
      chk("ov_sticky", 64'(overflow), 64'd1);

      // Pointer wrap with credit-respecting sender
      step(1, 0, '0, 0);
      dlog.delete();
      iack_cnt = 0;
      sent = 0;
      budget = 0;
      while (dlog.size() < 20 && budget < 200) begin
         bit iv;
         iv = (sent < 20) && (mq.size() < DEPTH);
         step(0, iv, DW'(sent), budget[0] == 1'b0);
         if (iv) sent++;
         budget++;
      end
      chk("wrap_done", 64'(budget < 200), 64'd1);
      chk("wrap_iack", 64'(iack_cnt), 64'd20);
      for (int i = 0; i < 20 && i < dlog.size(); i++)
         chk("wrap_data", 64'(dlog[i]), 64'(i));
      chk("wrap_ovf", 64'(overflow), 64'd0);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) step(0, 1, DW'(32'hE0 + i), 0);
      step(1, 1, DW'(32'hEE), 1);
      #1 chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      step(0, 1, DW'(32'hD1), 0);
      #1 chk("rst_d1_valid", 64'(out_valid), 64'd1);
      chk("rst_d1_data", 64'(out_data), 64'hD1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 149) == 0,
              $urandom_range(0, 9) < 6,
              DW'($urandom()),
              $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/router_wrap_input_credit_fifo.md
# router_wrap_input_credit_fifo

Per-input-port flit buffer for the router_wrap slice with credit-based flow control toward the upstream link. It captures incoming flits into a DEPTH-entry FIFO, presents them to the crossbar through a valid/ready handshake, and raises a one-cycle credit-return strobe, `iack_d`, for every flit dequeued. `iack_d` drives the D input of the slice's input-acknowledge flip-flop, which registers it onto the link. The upstream sender therefore sees each credit one cycle after the dequeue.

## Interface
- `DATA_WIDTH`, 32: flit width in bits.
- `DEPTH`, 4: FIFO entries; power of two, at least 2; equals the upstream sender's initial credit count.
- `PTR_WIDTH`, log2(DEPTH): derived; must not be overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a flit is present on `in_data` this cycle; there is no backpressure, because the sender spends one credit per flit.
- `in_data`  in  DATA_WIDTH  incoming flit.
- `out_valid`  out  1  the head flit is available.
- `out_data`  out  DATA_WIDTH  head flit; registered storage at the read pointer.
- `out_ready`  in  1  the crossbar accepts the head flit this cycle.
- `iack_d`  out  1  credit-return strobe to the input-acknowledge flop D; high exactly in cycles where a dequeue occurs.
- `occupancy`  out  PTR_WIDTH+1  current entry count, 0..DEPTH.
- `overflow`  out  1  sticky error flag: a flit arrived while the FIFO was full with no dequeue in the same cycle.

## Operation
- Storage: DEPTH×DATA_WIDTH register array, a write pointer, a read pointer, and a count register of PTR_WIDTH+1 bits. Both pointers wrap modulo DEPTH (natural wrap from DEPTH-1 to 0).
- Dequeue: `deq = out_valid & out_ready`. On `deq`, the read pointer increments.
- Enqueue condition: `enq = in_valid & (~full | deq)`.
  - When full, a simultaneous dequeue frees the slot and the write is accepted.
  - On `enq`, `in_data` is written at the write pointer and the write pointer increments.
- Count update:
  - +1 on enq only.
  - -1 on deq only.
  - Unchanged on both or neither.
- Flags:
  - `full` = (count == DEPTH).
  - `out_valid` = (count != 0).
  - `occupancy` = count.
- Dropped flit: `in_valid & full & ~deq`.
  - The flit is discarded and storage, pointers and count are unchanged.
  - `overflow` is set to 1 and stays set until reset. This is a protocol violation by the sender.
- Credit strobe: `iack_d = deq & ~reset`. It is combinational from `deq`, exactly one strobe per dequeued flit, and is never asserted for dropped flits.
- `out_valid` and `out_data` must not depend combinationally on `out_ready`.
- Data ordering: strict FIFO.
- Outputs have no X-propagation after reset; unwritten entries may hold any value, but `out_data` is don't-care while `out_valid` = 0.

## Timing
- Reset: on the clock edge with `reset` = 1:
  - Pointers, count and `overflow` go to 0.
  - Therefore `out_valid` = 0, `occupancy` = 0, `iack_d` = 0.
- Reset mid-operation discards all buffered flits with no credit strobes for them. The upstream sender is reset by the same signal and restores its DEPTH credits.
- `in_valid` and `out_ready` are ignored during any cycle with `reset` high.
- Write-to-read latency:
  - A flit enqueued at edge N appears on `out_valid`/`out_data` in cycle N+1.
  - There is no same-cycle bypass when empty.
- Sustained throughput:
  - One flit per cycle with `in_valid` and `out_ready` continuously high.
  - Occupancy holds steady at any level from 1 to DEPTH.
- Credit loop:
  - Dequeue in cycle N gives `iack_d` = 1 in cycle N.
  - The IACK flop Q is high in cycle N+1.
- Empty with `out_ready` high: `deq` = 0 and `iack_d` = 0.

## Test plan
- Reset then idle: `occupancy` = 0, `out_valid` = 0, `iack_d` = 0, `overflow` = 0 for 10 cycles.
- Fill and drain: with `out_ready` = 0, write 0xA0..0xA3.
  - `occupancy` steps 1,2,3,4.
  - Then with `out_ready` = 1, `out_data` reads 0xA0,0xA1,0xA2,0xA3 in consecutive cycles, `iack_d` high for exactly 4 cycles, `occupancy` ends at 0.
- Full plus simultaneous enqueue/dequeue: with 4 entries, `in_valid` = 1 (0xB0) and `out_ready` = 1 in the same cycle.
  - `occupancy` stays 4, `overflow` stays 0.
  - 0xB0 emerges fourth in order.
- Overflow: with the FIFO full and `out_ready` = 0, drive `in_valid` (0xCC).
  - Flit is dropped, `overflow` = 1 and sticky, `occupancy` = 4.
  - Drained contents contain no 0xCC.
- Pointer wrap: stream 20 flits (0..19) with `out_ready` toggling 1010…
  - Output sequence is 0..19 in order, no drops.
  - 20 `iack_d` pulses in total.
- Reset mid-stream: with 3 entries, assert `reset` for 1 cycle.
  - Next cycle: `occupancy` = 0, `out_valid` = 0, no `iack_d`.
  - A following write 0xD1 appears on `out_data` one cycle later.
